// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester-side and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [NUM_PORTS-1:0]            port_read;
  logic [NUM_PORTS-1:0]            port_write;
  logic [NUM_PORTS*BE_WIDTH-1:0]   port_byte_enable;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_address;
  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata;
  logic [NUM_PORTS-1:0]            port_resp;
  logic [NUM_PORTS-1:0]            port_err;
  logic [DATA_WIDTH-1:0]           port_rdata;
  logic                            mem_read;
  logic                            mem_write;
  logic [BE_WIDTH-1:0]             mem_byte_enable;
  logic [ADDR_WIDTH-1:0]           mem_address;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic                            mem_resp;
  logic [DATA_WIDTH-1:0]           mem_rdata;

  // arbiter side
  modport slave (
    input  port_read, port_write, port_byte_enable, port_address, port_wdata,
    input  mem_resp, mem_rdata,
    output port_resp, port_err, port_rdata,
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
  );

  // requesters plus memory model side
  modport master (
    output port_read, port_write, port_byte_enable, port_address, port_wdata,
    output mem_resp, mem_rdata,
    input  port_resp, port_err, port_rdata,
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin N-port memory arbiter, one outstanding transaction
// Optional response timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W    = $clog2(NUM_PORTS);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       grant;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       winner;
  logic [IDX_W-1:0]       next_ptr;
  logic                   found;
  logic [NUM_PORTS-1:0]   req;
  logic [NUM_PORTS-1:0]   grant_onehot;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [BE_WIDTH-1:0]    sel_be;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic                   sel_write;
  logic                   resp_fire;
  logic                   abort;

  assign req          = bus.port_read | bus.port_write;
  assign grant_onehot = NUM_PORTS'(1) << grant;
  assign next_ptr     = (winner == IDX_W'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;

  // Offset k is the outer loop so the lowest offset from rr_ptr wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (!found && rr_ptr == IDX_W'(j) && req[(j + k) % NUM_PORTS]) begin
          found  = 1'b1;
          winner = IDX_W'((j + k) % NUM_PORTS);
        end
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_be    = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (winner == IDX_W'(k)) begin
        sel_addr  = bus.port_address[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_be    = bus.port_byte_enable[k*BE_WIDTH +: BE_WIDTH];
        sel_wdata = bus.port_wdata[k*DATA_WIDTH +: DATA_WIDTH];
        sel_write = bus.port_write[k];
      end
    end
  end

  assign resp_fire = (state == ACCESS) && bus.mem_resp;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  // A real mem_resp in the expiry cycle wins over the abort.
  assign abort = (state == ACCESS) && !bus.mem_resp && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign abort          = 1'b0;
`endif

  assign bus.port_resp  = (resp_fire || abort) ? grant_onehot : '0;
  assign bus.port_err   = abort ? grant_onehot : '0;
  assign bus.port_rdata = resp_fire ? bus.mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      grant               <= '0;
      rr_ptr              <= '0;
      bus.mem_read        <= 1'b0;
      bus.mem_write       <= 1'b0;
      bus.mem_byte_enable <= '0;
      bus.mem_address     <= '0;
      bus.mem_wdata       <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_cnt            <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant               <= winner;
            rr_ptr              <= next_ptr;
            bus.mem_write       <= sel_write;
            bus.mem_read        <= !sel_write;
            bus.mem_byte_enable <= sel_be;
            bus.mem_address     <= sel_addr;
            bus.mem_wdata       <= sel_wdata;
            state               <= ACCESS;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt            <= '0;
`endif
          end
        end
        ACCESS: begin
          // Request inputs are not looked at here; mem_* stay as captured.
          if (resp_fire || abort) begin
            bus.mem_read        <= 1'b0;
            bus.mem_write       <= 1'b0;
            bus.mem_byte_enable <= '0;
            bus.mem_address     <= '0;
            bus.mem_wdata       <= '0;
            state               <= IDLE;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with a transaction-level model
module tb_mem_port_arbiter;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Requester intent per port; the model serves the first requester at or after next_port.
  logic          rd [NP];
  logic          wr [NP];
  logic [AW-1:0] addr [NP];
  logic [BW-1:0] be [NP];
  logic [DW-1:0] wd [NP];
  int            next_port;
  int            rearm;
  int            served;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int p = 0; p < NP; p++) begin
      bus.port_read[p]                 = rd[p];
      bus.port_write[p]                = wr[p];
      bus.port_address[p*AW +: AW]     = addr[p];
      bus.port_byte_enable[p*BW +: BW] = be[p];
      bus.port_wdata[p*DW +: DW]       = wd[p];
    end
  endtask

  task automatic clear_reqs();
    for (int p = 0; p < NP; p++) begin
      rd[p] = 1'b0; wr[p] = 1'b0; addr[p] = '0; be[p] = '0; wd[p] = '0;
    end
    apply();
  endtask

  function automatic int model_winner();
    for (int k = 0; k < NP; k++) begin
      if (rd[(next_port + k) % NP] || wr[(next_port + k) % NP]) return (next_port + k) % NP;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_resp = 1'b0;
    clear_reqs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    next_port = 0;
  endtask

  // Called at a negedge with the DUT idle and requests applied; returns the served port.
  task automatic run_round(input int dly, output int who);
    int            w;
    logic [DW-1:0] rdata;
    logic [AW-1:0] held;
    w     = model_winner();
    rdata = $urandom;
    if (w < 0) begin
      check("no_requester", 64'(1), 64'(0));
      who = -1;
      return;
    end
    @(negedge clk);
    check("mem_write", 64'(bus.mem_write), 64'(wr[w]));
    check("mem_read", 64'(bus.mem_read), 64'(!wr[w]));
    check("mem_address", 64'(bus.mem_address), 64'(addr[w]));
    check("mem_byte_enable", 64'(bus.mem_byte_enable), 64'(be[w]));
    check("mem_wdata", 64'(bus.mem_wdata), 64'(wd[w]));
    next_port = (w + 1) % NP;
    held = addr[w];
    if (rearm >= 0) begin
      rd[rearm] = 1'b1;
      apply();
      rearm = -1;
    end
    for (int d = 0; d < dly; d++) begin
      bus.mem_rdata = $urandom;
      @(negedge clk);
      check("hold_address", 64'(bus.mem_address), 64'(held));
      check("no_early_resp", 64'(bus.port_resp), 64'(0));
    end
    bus.mem_rdata = rdata;
    bus.mem_resp  = 1'b1;
    #1;
    check("port_resp", 64'(bus.port_resp), 64'(1) << w);
    check("port_rdata", 64'(bus.port_rdata), 64'(rdata));
    check("port_err", 64'(bus.port_err), 64'(0));
    @(negedge clk);
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = $urandom;
    #1;
    check("idle_mem_read", 64'(bus.mem_read), 64'(0));
    check("idle_mem_write", 64'(bus.mem_write), 64'(0));
    check("idle_port_resp", 64'(bus.port_resp), 64'(0));
    check("idle_port_rdata", 64'(bus.port_rdata), 64'(0));
    rd[w] = 1'b0;
    wr[w] = 1'b0;
    apply();
    who = w;
  endtask

  initial begin
    rst = 1'b1;
    rearm = -1;
    next_port = 0;
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    clear_reqs();

    @(negedge clk);
    check("rst_mem_read", 64'(bus.mem_read), 64'(0));
    check("rst_mem_write", 64'(bus.mem_write), 64'(0));
    check("rst_mem_address", 64'(bus.mem_address), 64'(0));
    check("rst_port_resp", 64'(bus.port_resp), 64'(0));
    check("rst_port_err", 64'(bus.port_err), 64'(0));
    check("rst_port_rdata", 64'(bus.port_rdata), 64'(0));
    rst = 1'b0;

    // single read from port0, memory answers after 3 cycles
    rd[0] = 1'b1; addr[0] = 32'h0000_1000; be[0] = 4'hF; apply();
    bus.mem_rdata = 32'hDEAD_BEEF;
    run_round(3, served);
    check("single_read_port", 64'(served), 64'(0));

    // two simultaneous requests from reset: port0 then port1
    do_reset();
    rd[0] = 1'b1; addr[0] = 32'h0000_1000; be[0] = 4'hF;
    rd[1] = 1'b1; addr[1] = 32'h0000_2000; be[1] = 4'hF; apply();
    run_round(1, served);
    check("pair_first", 64'(served), 64'(0));
    run_round(1, served);
    check("pair_second", 64'(served), 64'(1));

    // port1 write with partial byte enables
    wr[1] = 1'b1; addr[1] = 32'h0000_0080; be[1] = 4'b0101; wd[1] = 32'hA5A5_0000; apply();
    run_round(2, served);
    check("write_port", 64'(served), 64'(1));

    // read and write together: write wins
    rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h0000_0040; be[0] = 4'hC; wd[0] = 32'h1234_5678; apply();
    run_round(0, served);

    // mem_resp while idle produces nothing
    bus.mem_rdata = 32'h5555_AAAA;
    bus.mem_resp  = 1'b1;
    #1;
    check("idle_resp_ignored", 64'(bus.port_resp), 64'(0));
    check("idle_resp_rdata", 64'(bus.port_rdata), 64'(0));
    @(negedge clk);
    bus.mem_resp = 1'b0;
    check("idle_resp_no_access", 64'(bus.mem_read), 64'(0));

    // reset in the middle of an access
    rd[0] = 1'b1; addr[0] = 32'h0000_0300; be[0] = 4'hF; apply();
    @(negedge clk);
    check("pre_rst_mem_read", 64'(bus.mem_read), 64'(1));
    rst = 1'b1;
    #1;
    check("async_rst_mem_read", 64'(bus.mem_read), 64'(0));
    check("async_rst_address", 64'(bus.mem_address), 64'(0));
    clear_reqs();
    @(negedge clk);
    rst = 1'b0;
    next_port = 0;
    rd[1] = 1'b1; addr[1] = 32'h0000_0400; be[1] = 4'hF; apply();
    run_round(1, served);
    check("post_rst_alone", 64'(served), 64'(1));
    rd[0] = 1'b1; addr[0] = 32'h0000_0500; be[0] = 4'h3;
    rd[1] = 1'b1; addr[1] = 32'h0000_0600; be[1] = 4'h3; apply();
    run_round(0, served);
    check("post_rst_pair", 64'(served), 64'(0));
    run_round(0, served);

    // fairness: all ports request continuously with a 1-cycle memory
    do_reset();
    for (int p = 0; p < NP; p++) begin
      rd[p] = 1'b1; addr[p] = 32'(p * 256); be[p] = 4'hF;
    end
    apply();
    for (int i = 0; i < 6; i++) begin
      run_round(0, served);
      check("fair_order", 64'(served), 64'(i % NP));
      rearm = served;
    end
    rearm = -1;
    for (int i = 0; i < NP; i++) begin
      if (rd[i] || wr[i]) run_round(0, served);
    end

    // randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      int any = 0;
      for (int p = 0; p < NP; p++) begin
        if (!(rd[p] || wr[p]) && $urandom_range(0, 1) == 1) begin
          int op = $urandom_range(0, 2);
          rd[p] = (op != 1); wr[p] = (op != 0);
          addr[p] = $urandom; be[p] = 4'($urandom); wd[p] = $urandom;
        end
        if (rd[p] || wr[p]) any = 1;
      end
      if (any == 0) begin
        int p = $urandom_range(0, NP - 1);
        rd[p] = 1'b1; addr[p] = $urandom; be[p] = 4'hF;
      end
      apply();
      run_round($urandom_range(0, 3), served);
    end

`ifdef MEM_ARB_TIMEOUT_EN
    begin
      int n;
      do_reset();
      rd[0] = 1'b1; addr[0] = 32'h0000_0700; be[0] = 4'hF; apply();
      @(negedge clk);
      check("to_mem_read", 64'(bus.mem_read), 64'(1));
      bus.mem_rdata = 32'hFFFF_FFFF;
      n = 0;
      while (bus.port_resp == '0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("to_cycles", 64'(n), 64'(8));
      check("to_port_resp", 64'(bus.port_resp), 64'(1));
      check("to_port_err", 64'(bus.port_err), 64'(1));
      check("to_port_rdata", 64'(bus.port_rdata), 64'(0));
      rd[0] = 1'b0; apply();
      @(negedge clk);
      check("to_mem_read_drop", 64'(bus.mem_read), 64'(0));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-port memory arbiter between multiple requesters and a single memory port, e.g. split instruction/data fetch of the next-generation core, or a core plus DMA.
- Each requester side and the memory side use the same level-held read/write plus single-cycle resp handshake as the core memory interface.
- Arbitration is round-robin with registered memory-side outputs; one transaction is outstanding at a time.

Parameters:
- NUM_PORTS, 2, number of requester ports (>=2).
- ADDR_WIDTH, 32, address width in bits.
- DATA_WIDTH, 32, data width in bits (multiple of 8); BE_WIDTH = DATA_WIDTH/8.
- TIMEOUT_CYCLES, 64, cycles of missing mem_resp before abort (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- port_read  in  NUM_PORTS  per-port read request, held until port_resp.
- port_write  in  NUM_PORTS  per-port write request, held until port_resp.
- port_byte_enable  in  NUM_PORTS*BE_WIDTH  per-port byte enables; port i occupies slice [i*BE_WIDTH +: BE_WIDTH].
- port_address  in  NUM_PORTS*ADDR_WIDTH  per-port address, sliced as above.
- port_wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data, sliced as above.
- port_resp  out  NUM_PORTS  one-hot completion pulse.
- port_err  out  NUM_PORTS  abort flag, valid with port_resp.
- port_rdata  out  DATA_WIDTH  shared read data, valid when any port_resp bit is high.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_byte_enable  out  BE_WIDTH  memory byte enables.
- mem_address  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_resp  in  1  memory completion, one-cycle pulse.
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_resp.

Behaviour:
- Reset (async): state=IDLE, grant=0, rr_ptr=0. All mem_* outputs are 0. port_resp=0 and port_err=0.
- FSM states: IDLE and ACCESS.
- IDLE, arbitration:
  - Port i is requesting when port_read[i] or port_write[i] is high.
  - Search starts at rr_ptr and wraps modulo NUM_PORTS; the first requesting port wins.
  - On the clock edge: grant<=winner; register that port's address, byte_enable and wdata into mem_*; rr_ptr<=(winner+1) mod NUM_PORTS; state<=ACCESS.
  - No requesters: remain in IDLE with all outputs 0.
- Operation select: if port_write is high for the winner, mem_write<=1 and mem_read<=0. Otherwise mem_read<=1. Write wins if both are high.
- Latency: a request first seen in IDLE at cycle t drives mem_read/mem_write from cycle t+1. The arbitration overhead is exactly 1 cycle.
- ACCESS:
  - mem_* outputs hold stable until mem_resp.
  - In the cycle mem_resp=1, port_resp[grant]=1 combinationally and port_rdata=mem_rdata. On that edge: mem_read<=0, mem_write<=0, state<=IDLE.
  - Back-to-back: the next grant is evaluated in the following IDLE cycle. The just-served port has dropped its request by then, so there is no double service.
- port_rdata outside a resp cycle: 0.
- Requester dropping its request mid-ACCESS: protocol violation. The arbiter ignores it, completes the transaction and still pulses port_resp.
- Request inputs changing during ACCESS: no effect; mem_* are registered.
- mem_resp in IDLE: ignored, and no port_resp is produced.
- Reset mid-ACCESS: outputs drop asynchronously and the outstanding transaction is abandoned. rr_ptr returns to 0.
- Fairness: with all ports continuously requesting, the service order is 0,1,...,N-1,0,...

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to ACCESS and increments each ACCESS cycle without mem_resp.
  - When the counter reaches TIMEOUT_CYCLES: pulse port_resp[grant] and port_err[grant] for one cycle, force port_rdata=0, deassert mem_read/mem_write on the edge, and go to IDLE.
  - mem_resp in the same cycle as expiry takes priority: normal completion, port_err=0.
- Not defined: no counter is present, port_err is tied to 0, and ACCESS waits indefinitely.

Test Plan:
- NUM_PORTS=2, port0 read at 0x0000_1000, memory returns 0xDEADBEEF after 3 cycles -> mem_read high from t+1 with mem_address=0x1000; port_resp[0] pulses once with port_rdata=0xDEADBEEF; port1 never sees resp.
- Port0 and port1 both request in the same cycle from reset -> port0 is served first, then port1; mem_address switches 0x1000 -> 0x2000 with one IDLE cycle between.
- NUM_PORTS=4, all ports continuously request, each with a 1-cycle memory -> grant order 0,1,2,3,0,1; no port is starved.
- Port1 write 0xA5A5_0000 at 0x80 with byte_enable 4'b0101 -> mem_write=1, mem_byte_enable=0101, mem_wdata=0xA5A5_0000; port_resp[1] pulses on mem_resp.
- Port0 asserts read and write together -> mem_write=1, mem_read=0.
- Reset asserted mid-ACCESS -> mem_read=0 immediately (async); after release, port1 requesting alone is granted; a simultaneous port0+port1 request then grants port0 (rr_ptr=0).
- With MEM_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, memory never responds -> after 8 ACCESS cycles, port_resp[0]=port_err[0]=1 with port_rdata=0, and mem_read drops.
